// File: rtl/spi_frame_controller.sv
// spi_frame_controller: frames SPI transactions as addr, R/W, data.
// Drives register-memory reads/writes and serializes read data on MISO.
module spi_frame_controller #(
  parameter int addrwidth = 7,
  parameter int datawidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_cond,
  input  logic                 sclk_pos,
  input  logic                 sclk_neg,
  input  logic                 mosi_cond,
  input  logic [datawidth-1:0] mem_rdata,
  output logic [addrwidth-1:0] mem_addr,
  output logic [datawidth-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 frame_done
);

  localparam int maxw = (addrwidth > datawidth) ? addrwidth : datawidth;
  localparam int cw = $clog2(maxw + 1);
  localparam logic [cw-1:0] alast = cw'(addrwidth - 1);
  localparam logic [cw-1:0] dlast = cw'(datawidth - 1);
  localparam logic [cw-1:0] one = cw'(1);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_RW,
    READ_WAIT,
    READ_LOAD,
    READ_SEND,
    WRITE_GET,
    WRITE_COMMIT,
    DONE
  } state_t;

  state_t               state;
  logic [cw-1:0]        cnt;
  logic [addrwidth-1:0] addr_sr;
  logic [datawidth-1:0] tx;

  // Frame sequencer; CS high aborts any frame and beats same-cycle SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_sr    <= '0;
      tx         <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (state != IDLE && cs_cond) begin
        state   <= IDLE;
        cnt     <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (!cs_cond) state <= GET_ADDR;
          end
          GET_ADDR: begin
            if (sclk_pos) begin
              addr_sr <= {addr_sr[addrwidth-2:0], mosi_cond};
              if (cnt == alast) begin
                cnt   <= '0;
                state <= GET_RW;
              end else begin
                cnt <= cnt + one;
              end
            end
          end
          GET_RW: begin
            if (sclk_pos) begin
              mem_addr <= addr_sr;
              cnt      <= '0;
              state    <= mosi_cond ? READ_WAIT : WRITE_GET;
            end
          end
          READ_WAIT: begin
            miso_oe <= 1'b1;
            state   <= READ_LOAD;
          end
          READ_LOAD: begin
            tx    <= mem_rdata;
            state <= READ_SEND;
          end
          READ_SEND: begin
            if (sclk_neg) begin
              miso <= tx[datawidth-1];
              tx   <= {tx[datawidth-2:0], 1'b0};
            end
            if (sclk_pos) begin
              if (cnt == dlast) begin
                cnt        <= '0;
                miso       <= 1'b0;
                miso_oe    <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                cnt <= cnt + one;
              end
            end
          end
          WRITE_GET: begin
            if (sclk_pos) begin
              mem_wdata <= {mem_wdata[datawidth-2:0], mosi_cond};
              if (cnt == dlast) begin
                cnt    <= '0;
                mem_we <= 1'b1;
                state  <= WRITE_COMMIT;
              end else begin
                cnt <= cnt + one;
              end
            end
          end
          WRITE_COMMIT: begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
          DONE: begin
            cnt <= '0;
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
// tb_spi_frame_controller: directed SPI frames against a memory stub.
// Expected writes, done pulses and MISO bits come from a bench-side model.
module tb_spi_frame_controller;
  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_cond = 1'b1;
  logic          sclk_pos = 1'b0;
  logic          sclk_neg = 1'b0;
  logic          mosi_cond = 1'b0;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          miso;
  logic          miso_oe;
  logic          frame_done;

  always #5 clk = ~clk;

  spi_frame_controller #(.addrwidth(AW), .datawidth(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs_cond(cs_cond),
    .sclk_pos(sclk_pos),
    .sclk_neg(sclk_neg),
    .mosi_cond(mosi_cond),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .miso(miso),
    .miso_oe(miso_oe),
    .frame_done(frame_done)
  );

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] model_mem [2**AW];

  // Synchronous-read register memory stub
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int checks = 0;
  int errors = 0;
  wr_t exp_wr[$];
  wr_t wcur;
  int exp_done = 0;
  int we_seen = 0;
  int done_seen = 0;
  logic in_read = 1'b0;
  logic chk_miso = 1'b0;
  logic exp_bit = 1'b0;
  logic [DW-1:0] rx = '0;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        we_seen++;
        last_wa = mem_addr;
        last_wd = mem_wdata;
      end
      if (exp_wr.size() == 0) begin
        check("no_we", mem_we, 0);
      end else if (mem_we) begin
        wcur = exp_wr.pop_front();
        check("we_addr", mem_addr, wcur.a);
        check("we_data", mem_wdata, wcur.d);
      end
      if (frame_done) done_seen++;
      if (exp_done == 0) check("no_done", frame_done, 0);
      else if (frame_done) exp_done--;
      if (!in_read) check("oe_low", miso_oe, 0);
      if (chk_miso) begin
        check("miso_oe_hi", miso_oe, 1);
        check("miso_bit", miso, exp_bit);
        rx = {rx[DW-2:0], miso};
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b, input logic chk, input logic eb,
                      input logic clr);
    mosi_cond = b;
    sclk_pos = 1'b1;
    chk_miso = chk;
    exp_bit = eb;
    tick(1);
    sclk_pos = 1'b0;
    chk_miso = 1'b0;
    if (clr) in_read = 1'b0;
    tick(3);
    sclk_neg = 1'b1;
    tick(1);
    sclk_neg = 1'b0;
    tick(3);
  endtask

  task automatic start_frame();
    cs_cond = 1'b0;
    tick(3);
  endtask

  task automatic send_hdr(input logic [AW-1:0] a, input logic rw);
    for (int i = AW - 1; i >= 0; i--) sbit(a[i], 1'b0, 1'b0, 1'b0);
    if (rw) in_read = 1'b1;
    sbit(rw, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic end_frame();
    tick(3);
    cs_cond = 1'b1;
    tick(4);
    check("we_pending", exp_wr.size(), 0);
    check("done_pending", exp_done, 0);
  endtask

  task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr.push_back({a, d});
    exp_done++;
    model_mem[a] = d;
    start_frame();
    send_hdr(a, 1'b0);
    for (int i = DW - 1; i >= 0; i--) sbit(d[i], 1'b0, 1'b0, 1'b0);
    end_frame();
  endtask

  task automatic read_frame(input logic [AW-1:0] a, input int trail);
    logic [DW-1:0] e;
    e = model_mem[a];
    exp_done++;
    rx = '0;
    start_frame();
    send_hdr(a, 1'b1);
    for (int i = DW - 1; i >= 0; i--)
      sbit(1'b0, 1'b1, e[i], (i == 0) ? 1'b1 : 1'b0);
    check("rx_byte", rx, e);
    for (int k = 0; k < trail; k++)
      sbit(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end_frame();
  endtask

  int w0;
  int d0;
  logic [DW-1:0] rbyte;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = DW'(i * 3 + 1);
      model_mem[i] = DW'(i * 3 + 1);
    end
    mem[7'h15] = 8'h96;
    model_mem[7'h15] = 8'h96;

    tick(3);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_we", mem_we, 0);
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    tick(3);

    w0 = we_seen;
    d0 = done_seen;
    write_frame(7'h2A, 8'hC3);
    check("wr1_pulses", we_seen - w0, 1);
    check("wr1_dones", done_seen - d0, 1);
    check("wr1_addr", last_wa, 7'h2A);
    check("wr1_data", last_wd, 8'hC3);

    w0 = we_seen;
    read_frame(7'h15, 0);
    check("rd1_byte", rx, 8'h96);
    check("rd1_no_we", we_seen - w0, 0);

    w0 = we_seen;
    d0 = done_seen;
    start_frame();
    send_hdr(7'h33, 1'b0);
    for (int i = 0; i < 4; i++) sbit(1'b1, 1'b0, 1'b0, 1'b0);
    cs_cond = 1'b1;
    tick(4);
    check("abort_we", we_seen - w0, 0);
    check("abort_done", done_seen - d0, 0);
    write_frame(7'h01, 8'h55);
    check("abort_next_addr", last_wa, 7'h01);
    check("abort_next_data", last_wd, 8'h55);
    read_frame(7'h01, 0);
    check("rd_back_55", rx, 8'h55);

    w0 = we_seen;
    d0 = done_seen;
    start_frame();
    send_hdr(7'h44, 1'b0);
    for (int i = 0; i < DW - 1; i++) sbit(1'b1, 1'b0, 1'b0, 1'b0);
    mosi_cond = 1'b1;
    sclk_pos = 1'b1;
    cs_cond = 1'b1;
    tick(1);
    sclk_pos = 1'b0;
    tick(5);
    check("race_we", we_seen - w0, 0);
    check("race_done", done_seen - d0, 0);

    w0 = we_seen;
    read_frame(7'h15, 3);
    check("trail_no_we", we_seen - w0, 0);
    write_frame(7'h7F, 8'hA5);
    read_frame(7'h7F, 0);
    check("rd_back_a5", rx, 8'hA5);

    d0 = done_seen;
    rbyte = model_mem[7'h15];
    start_frame();
    send_hdr(7'h15, 1'b1);
    for (int i = DW - 1; i >= DW - 3; i--)
      sbit(1'b0, 1'b1, rbyte[i], 1'b0);
    check("pre_rst_oe", miso_oe, 1);
    check("pre_rst_miso", miso, 1);
    #3;
    rst_n = 1'b0;
    in_read = 1'b0;
    #1;
    check("arst_oe", miso_oe, 0);
    check("arst_miso", miso, 0);
    cs_cond = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("arst_done", done_seen - d0, 0);
    check("arst_addr", mem_addr, 0);
    write_frame(7'h0A, 8'h3C);
    read_frame(7'h0A, 0);
    check("rd_back_3c", rx, 8'h3C);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_controller.md
Name: spi_frame_controller

Overview:
- Consumes the conditioned SPI pins (chip select, SCLK edge pulses, MOSI) produced by the per-pin input conditioners.
- Frames each transaction as address, then R/W bit, then data.
- Issues single-cycle write strobes or synchronous reads to a small register memory, and serializes read data onto MISO.
- Sits between the input conditioners and the memory/MISO output buffer of the SPI memory top level.

Parameters:
addrwidth, 7, address bits per frame (memory depth 2^addrwidth)
datawidth, 8, data bits per frame and memory word width

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
cs_cond  input  1  conditioned chip select, active low
sclk_pos  input  1  1-clk pulse at conditioned SCLK rising edge
sclk_neg  input  1  1-clk pulse at conditioned SCLK falling edge
mosi_cond  input  1  conditioned MOSI level
mem_rdata  input  datawidth  memory read data, valid 1 clk after mem_addr is presented
mem_addr  output  addrwidth  memory address
mem_wdata  output  datawidth  memory write data
mem_we  output  1  memory write strobe, 1 clk wide
miso  output  1  serial read data
miso_oe  output  1  MISO tristate-buffer enable
frame_done  output  1  1-clk pulse when a complete frame finishes

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, bit counter 0, shift registers 0.
- Protocol:
  - MSB first.
  - MOSI is sampled only on sclk_pos cycles.
  - MISO changes only on sclk_neg cycles.
  - Input precondition: successive sclk_pos and sclk_neg pulses are at least 3 clk apart (guaranteed by the conditioners).
- States:
  - IDLE: wait for cs_cond==0, then go to GET_ADDR. Counter cleared.
  - GET_ADDR: on each sclk_pos, shift mosi_cond into the address register and count. After the addrwidth-th sample, go to GET_RW.
  - GET_RW: on sclk_pos, sample R/W (1 = read). Present mem_addr on the next clk. Read goes to READ_WAIT; write goes to WRITE_GET.
  - READ_WAIT: hold 1 clk so mem_rdata settles, go to READ_LOAD.
  - READ_LOAD: load tx shift register from mem_rdata; assert miso_oe; go to READ_SEND.
  - READ_SEND: on each sclk_neg, miso <= tx MSB and tx shifts left. Count sclk_pos. After datawidth sclk_pos, go to DONE.
  - WRITE_GET: on each sclk_pos, shift mosi_cond into mem_wdata. After datawidth samples, go to WRITE_COMMIT.
  - WRITE_COMMIT: mem_we=1 for exactly this one cycle, with stable mem_addr/mem_wdata; go to DONE.
  - DONE: frame_done=1 on entry cycle only; miso_oe=0; all sclk pulses ignored. On cs_cond==1, go to IDLE.
- First read bit timing: the first MISO bit is driven on the first sclk_neg after the R/W sample. READ_WAIT and READ_LOAD therefore complete before that edge by the 3-clk spacing.
- CS deassert:
  - cs_cond==1 in any state other than IDLE returns to IDLE on the next clk; miso_oe drops that clk.
  - A partial write never asserts mem_we.
  - frame_done is not pulsed on an aborted frame.
  - If cs_cond rises in the same cycle as sclk_pos, CS wins: the sample is discarded.
- Ignored inputs:
  - sclk pulses in IDLE or DONE.
  - sclk_neg outside READ_SEND.
  - sclk_pos and sclk_neg asserted together: undefined input, no requirement.
- Counter: sized ceil(log2(max(addrwidth, datawidth)+1)) bits; cleared on every state transition; never wraps within a frame.
- mem_addr holds its value after the frame until the next GET_RW completes.
- Reset mid-frame: rst_n low immediately forces the reset values (miso_oe=0 without waiting for clk). After release, the block waits in IDLE. If cs_cond is already 0 at release, it starts GET_ADDR. That frame is corrupt by design; no requirement on its content.

Test Plan:
- Write: cs low, shift addr 0x2A, R/W 0, data 0xC3 -> exactly one mem_we pulse with mem_addr=0x2A and mem_wdata=0xC3; frame_done pulses once; miso_oe stays 0 throughout.
- Read: cs low, addr 0x15, R/W 1, memory model returns 0x96 -> miso sampled at the next 8 sclk_pos is 1,0,0,1,0,1,1,0; miso_oe high from READ_LOAD until DONE; mem_we never asserted.
- Abort: write frame with cs raised after 4 data bits -> no mem_we, no frame_done, state IDLE. A following full write of 0x55 to 0x01 succeeds.
- CS race: cs_cond rises in the same clk as the 8th write-data sclk_pos -> no mem_we, no frame_done.
- Trailing clocks: after a complete read, 3 extra SCLK cycles with cs low -> miso_oe stays 0, no mem_we. cs high then low starts a clean frame.
- Async reset: rst_n pulsed low mid-READ_SEND between clk edges -> miso_oe and miso go 0 before the next posedge; after release with cs high, state is IDLE.
